alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter DECIMAL_EN, default 1, enables BCD arithmetic for ADD/SUB when status D=1.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 valid_i  input  1  upstream operation valid.
REQ-006 ready_o  output  1  block accepts an operation this cycle.
REQ-007 operation_i  input  5  ALU_* operation code from Global_Macros.v.
REQ-008 status_i  input  8  processor status in, N/V/P/B/D/I/Z/C bit positions per Global_Macros.v.
REQ-009 operand1_i, operand2_i  input  DATA_W  operands.
REQ-010 valid_o  output  1  result valid.
REQ-011 ready_i  input  1  downstream accepts the result.
REQ-012 result_o  output  DATA_W  registered result.
REQ-013 status_o  output  8  registered updated status.

Function
REQ-014 Two-stage pipeline: S1 registers inputs and computes binary result plus raw carries; S2 applies decimal adjust and flags, and drives the outputs.
REQ-015 Transfer in occurs when valid_i && ready_o; transfer out occurs when valid_o && ready_i.
REQ-016 Latency SHALL be exactly 2 cycles from accept to valid_o with ready_i held high; throughput SHALL be 1 op/cycle.
REQ-017 Backpressure: a stage advances only when the next stage is empty or draining; ready_o = !S1_valid || !S2_valid || ready_i.
REQ-018 While valid_o && !ready_i, result_o and status_o SHALL hold stable.
REQ-019 ADD: op1 + op2 + C; C_out = carry out of bit DATA_W-1; V = signed overflow.
REQ-020 SUB: op2 - op1 - (1-C); C_out = 1 when no borrow; V = signed overflow of op2 - op1.
REQ-021 CMP: op2 - op1 with no carry-in; C = (op2 >= op1) unsigned; V unchanged.
REQ-022 When DECIMAL_EN=1 and D=1, ADD/SUB SHALL adjust per nibble (+6/-6) with the decimal carry chained nibble-to-nibble, and C SHALL be the decimal carry/no-borrow.
REQ-023 In decimal mode, N, V and Z SHALL be taken from the binary (unadjusted) result.
REQ-024 AND/ORA/XOR are bitwise; INC/DEC are op1 +/- 1 mod 2^DATA_W; C and V are unchanged.
REQ-025 SHL/SHR: C = bit shifted out; 0 is shifted in.
REQ-026 ROL/ROR: C_in from status_i C; C = bit shifted out.
REQ-027 ITO/BRK pass op1; BRK sets B=1 and I=1 and keeps N and Z from status_i.
REQ-028 ITF loads status_o from op1[7:0].
REQ-029 CLC/SEC/CLD/SED/CLI/SEI/CLV clear or set the single named bit.
REQ-030 N = result[DATA_W-1]; Z = (result == 0) across the full DATA_W; both are updated for every result-producing op.
REQ-031 Bits P and B pass from status_i except on BRK/ITF.
REQ-032 Unlisted codes: result = op1, status_o = status_i.
REQ-033 Every flag SHALL be a function only of the accepted op's captured inputs; no state carries between ops.

Reset
REQ-034 rst_i high SHALL immediately clear both stage valids; valid_o=0, result_o=0, status_o=8'h00, ready_o=1.
REQ-035 In-flight ops at reset SHALL be discarded with no output transfer.
REQ-036 The first accept SHALL be possible on the first rising edge after rst_i deasserts.

Verification
REQ-037 DATA_W=8, ADD, D=1, C=0, 0x58+0x46 -> result 0x04, C=1, valid_o 2 cycles after accept.
REQ-038 ADD, D=0, C=0, 0x7F+0x01 -> result 0x80, N=1, V=1, Z=0, C=0.
REQ-039 SUB, D=0, C=1, op2=0x10, op1=0x20 -> result 0xF0, C=0, N=1; CMP op2=op1=0x33 -> Z=1, C=1.
REQ-040 Stream 3 ops with ready_i=0 -> two ops held, ready_o=0 on the third cycle, outputs stable; raise ready_i -> all 3 results delivered in order, one per cycle.
REQ-041 Assert rst_i with 2 ops in flight -> valid_o=0 at once, no result emitted, status_o=0x00.
REQ-042 DATA_W=16, ADD, C=0, 0xFFFF+0x0001 -> result 0x0000, Z=1, C=1, N=0.

Source files
------------

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage pipelined ALU with valid/ready handshakes.
//                Stage 1 captures the operation and computes the binary
//                result and carry. Stage 2 applies the BCD adjust, derives
//                the status flags and holds the registered outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
  parameter int DATA_W     = 8,
  parameter int DECIMAL_EN = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [4:0]        operation_i,
  input  logic [7:0]        status_i,
  input  logic [DATA_W-1:0] operand1_i,
  input  logic [DATA_W-1:0] operand2_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic [7:0]        status_o
);

  // Operation codes
  localparam logic [4:0] c_OP_ADD = 5'd0;
  localparam logic [4:0] c_OP_SUB = 5'd1;
  localparam logic [4:0] c_OP_CMP = 5'd2;
  localparam logic [4:0] c_OP_AND = 5'd3;
  localparam logic [4:0] c_OP_ORA = 5'd4;
  localparam logic [4:0] c_OP_XOR = 5'd5;
  localparam logic [4:0] c_OP_INC = 5'd6;
  localparam logic [4:0] c_OP_DEC = 5'd7;
  localparam logic [4:0] c_OP_SHL = 5'd8;
  localparam logic [4:0] c_OP_SHR = 5'd9;
  localparam logic [4:0] c_OP_ROL = 5'd10;
  localparam logic [4:0] c_OP_ROR = 5'd11;
  localparam logic [4:0] c_OP_ITO = 5'd12;
  localparam logic [4:0] c_OP_BRK = 5'd13;
  localparam logic [4:0] c_OP_ITF = 5'd14;
  localparam logic [4:0] c_OP_CLC = 5'd15;
  localparam logic [4:0] c_OP_SEC = 5'd16;
  localparam logic [4:0] c_OP_CLD = 5'd17;
  localparam logic [4:0] c_OP_SED = 5'd18;
  localparam logic [4:0] c_OP_CLI = 5'd19;
  localparam logic [4:0] c_OP_SEI = 5'd20;
  localparam logic [4:0] c_OP_CLV = 5'd21;

  // Status bit positions
  localparam int c_ST_N = 7;
  localparam int c_ST_V = 6;
  localparam int c_ST_B = 4;
  localparam int c_ST_D = 3;
  localparam int c_ST_I = 2;
  localparam int c_ST_Z = 1;
  localparam int c_ST_C = 0;

  localparam int c_MSB = DATA_W - 1;
  localparam int c_NIB = DATA_W / 4;
  localparam logic [DATA_W:0]   c_ONE_X = {{DATA_W{1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] c_ONE_D = {{(DATA_W-1){1'b0}}, 1'b1};

  // Stage 1 state
  logic              r1_valid;
  logic [4:0]        r1_op;
  logic [7:0]        r1_st;
  logic [DATA_W-1:0] r1_a;
  logic [DATA_W-1:0] r1_b;
  logic [DATA_W:0]   r1_bin;

  // Stage 2 state (drives the outputs)
  logic              r2_valid;
  logic [DATA_W-1:0] r2_result;
  logic [7:0]        r2_status;

  logic              w_s2_load;
  logic              w_accept;
  logic [DATA_W:0]   w_cin;
  logic [DATA_W:0]   w_bin;
  logic [DATA_W-1:0] w_dec_res;
  logic              w_dec_c;
  logic              w_dec_mode;
  logic [DATA_W-1:0] w_res;
  logic [7:0]        w_st;
  logic              w_nz_upd;
  logic [DATA_W-1:0] w_nz_src;

  // Stage 2 can take new data when empty or when its result leaves this cycle;
  // stage 1 can then always move forward, so it accepts whenever it is empty
  // or stage 2 is loadable.
  assign w_s2_load = !r2_valid || ready_i;
  assign ready_o   = !r1_valid || w_s2_load;
  assign w_accept  = valid_i && ready_o;

  // Stage 1 binary datapath; bit DATA_W carries the raw carry / shifted-out bit
  always_comb begin
    w_cin = {{DATA_W{1'b0}}, status_i[c_ST_C]};
    w_bin = {1'b0, operand1_i};
    case (operation_i)
      c_OP_ADD: w_bin = {1'b0, operand1_i} + {1'b0, operand2_i} + w_cin;
      c_OP_SUB: w_bin = {1'b0, operand2_i} + {1'b0, ~operand1_i} + w_cin;
      c_OP_CMP: w_bin = {1'b0, operand2_i} + {1'b0, ~operand1_i} + c_ONE_X;
      c_OP_AND: w_bin = {1'b0, operand1_i & operand2_i};
      c_OP_ORA: w_bin = {1'b0, operand1_i | operand2_i};
      c_OP_XOR: w_bin = {1'b0, operand1_i ^ operand2_i};
      c_OP_INC: w_bin = {1'b0, operand1_i + c_ONE_D};
      c_OP_DEC: w_bin = {1'b0, operand1_i - c_ONE_D};
      c_OP_SHL: w_bin = {operand1_i, 1'b0};
      c_OP_SHR: w_bin = {operand1_i[0], 1'b0, operand1_i[DATA_W-1:1]};
      c_OP_ROL: w_bin = {operand1_i, status_i[c_ST_C]};
      c_OP_ROR: w_bin = {operand1_i[0], status_i[c_ST_C], operand1_i[DATA_W-1:1]};
      default:  w_bin = {1'b0, operand1_i};
    endcase
  end

  // Stage 1 registers: capture the accepted op and its binary result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r1_valid <= 1'b0;
      r1_op    <= '0;
      r1_st    <= '0;
      r1_a     <= '0;
      r1_b     <= '0;
      r1_bin   <= '0;
    end else if (ready_o) begin
      r1_valid <= valid_i;
      if (w_accept) begin
        r1_op  <= operation_i;
        r1_st  <= status_i;
        r1_a   <= operand1_i;
        r1_b   <= operand2_i;
        r1_bin <= w_bin;
      end
    end
  end

  generate
    if (DECIMAL_EN != 0) begin : g_dec_on
      logic       w_dc;
      logic [4:0] w_nib;
      // Nibble-serial BCD add/subtract with the decimal carry chained upward
      always_comb begin
        w_dec_res = '0;
        w_dc      = r1_st[c_ST_C];
        w_nib     = '0;
        for (int i = 0; i < c_NIB; i++) begin
          if (r1_op == c_OP_SUB) begin
            w_nib = {1'b0, r1_b[4*i +: 4]} - {1'b0, r1_a[4*i +: 4]} - {4'b0000, ~w_dc};
            w_dec_res[4*i +: 4] = w_nib[4] ? (w_nib[3:0] - 4'd6) : w_nib[3:0];
            w_dc  = ~w_nib[4];
          end else begin
            w_nib = {1'b0, r1_a[4*i +: 4]} + {1'b0, r1_b[4*i +: 4]} + {4'b0000, w_dc};
            w_dec_res[4*i +: 4] = (w_nib > 5'd9) ? (w_nib[3:0] + 4'd6) : w_nib[3:0];
            w_dc  = (w_nib > 5'd9);
          end
        end
        w_dec_c = w_dc;
      end
    end else begin : g_dec_off
      assign w_dec_res = r1_bin[DATA_W-1:0];
      assign w_dec_c   = r1_bin[DATA_W];
    end
  endgenerate

  assign w_dec_mode = (DECIMAL_EN != 0) && r1_st[c_ST_D] &&
                      ((r1_op == c_OP_ADD) || (r1_op == c_OP_SUB));

  // Stage 2 result select and flag update; N/Z/V always use the binary result
  always_comb begin
    w_res    = r1_bin[DATA_W-1:0];
    w_st     = r1_st;
    w_nz_upd = 1'b0;
    w_nz_src = r1_bin[DATA_W-1:0];
    case (r1_op)
      c_OP_ADD: begin
        w_nz_upd     = 1'b1;
        w_st[c_ST_C] = w_dec_mode ? w_dec_c : r1_bin[DATA_W];
        w_st[c_ST_V] = (r1_a[c_MSB] == r1_b[c_MSB]) && (r1_bin[c_MSB] != r1_a[c_MSB]);
        if (w_dec_mode) w_res = w_dec_res;
      end
      c_OP_SUB: begin
        w_nz_upd     = 1'b1;
        w_st[c_ST_C] = w_dec_mode ? w_dec_c : r1_bin[DATA_W];
        w_st[c_ST_V] = (r1_a[c_MSB] != r1_b[c_MSB]) && (r1_bin[c_MSB] != r1_b[c_MSB]);
        if (w_dec_mode) w_res = w_dec_res;
      end
      c_OP_CMP: begin
        w_nz_upd     = 1'b1;
        w_st[c_ST_C] = r1_bin[DATA_W];
      end
      c_OP_AND, c_OP_ORA, c_OP_XOR, c_OP_INC, c_OP_DEC, c_OP_ITO: begin
        w_nz_upd = 1'b1;
      end
      c_OP_SHL, c_OP_SHR, c_OP_ROL, c_OP_ROR: begin
        w_nz_upd     = 1'b1;
        w_st[c_ST_C] = r1_bin[DATA_W];
      end
      c_OP_BRK: begin
        w_st[c_ST_B] = 1'b1;
        w_st[c_ST_I] = 1'b1;
      end
      c_OP_ITF: w_st = r1_a[7:0];
      c_OP_CLC: w_st[c_ST_C] = 1'b0;
      c_OP_SEC: w_st[c_ST_C] = 1'b1;
      c_OP_CLD: w_st[c_ST_D] = 1'b0;
      c_OP_SED: w_st[c_ST_D] = 1'b1;
      c_OP_CLI: w_st[c_ST_I] = 1'b0;
      c_OP_SEI: w_st[c_ST_I] = 1'b1;
      c_OP_CLV: w_st[c_ST_V] = 1'b0;
      default: ;
    endcase
    if (w_nz_upd) begin
      w_st[c_ST_N] = w_nz_src[c_MSB];
      w_st[c_ST_Z] = (w_nz_src == '0);
    end
  end

  // Stage 2 registers: outputs only change when the stage is loadable
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r2_valid  <= 1'b0;
      r2_result <= '0;
      r2_status <= '0;
    end else if (w_s2_load) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_result <= w_res;
        r2_status <= w_st;
      end
    end
  end

  assign valid_o  = r2_valid;
  assign result_o = r2_result;
  assign status_o = r2_status;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Self-checking bench for alu_pipe (8-bit and 16-bit builds).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

  localparam logic [4:0] c_OP_ADD = 5'd0,  c_OP_SUB = 5'd1,  c_OP_CMP = 5'd2;
  localparam logic [4:0] c_OP_AND = 5'd3,  c_OP_ORA = 5'd4,  c_OP_XOR = 5'd5;
  localparam logic [4:0] c_OP_INC = 5'd6,  c_OP_DEC = 5'd7,  c_OP_SHL = 5'd8;
  localparam logic [4:0] c_OP_SHR = 5'd9,  c_OP_ROL = 5'd10, c_OP_ROR = 5'd11;
  localparam logic [4:0] c_OP_ITO = 5'd12, c_OP_BRK = 5'd13, c_OP_ITF = 5'd14;
  localparam logic [4:0] c_OP_CLC = 5'd15, c_OP_SEC = 5'd16, c_OP_CLD = 5'd17;
  localparam logic [4:0] c_OP_SED = 5'd18, c_OP_CLI = 5'd19, c_OP_SEI = 5'd20;
  localparam logic [4:0] c_OP_CLV = 5'd21;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       valid_i = 1'b0, ready_o, valid_o, ready_i = 1'b0;
  logic [4:0] operation_i = '0;
  logic [7:0] status_i = '0, operand1_i = '0, operand2_i = '0, result_o, status_o;

  logic        v16 = 1'b0, r16_o, vo16, ri16 = 1'b1;
  logic [4:0]  op16 = '0;
  logic [7:0]  st16 = '0, so16;
  logic [15:0] a16 = '0, b16 = '0, res16;

  always #5 clk = ~clk;

  alu_pipe #(.DATA_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .operation_i(operation_i), .status_i(status_i),
    .operand1_i(operand1_i), .operand2_i(operand2_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .status_o(status_o));

  alu_pipe #(.DATA_W(16)) dut16 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(v16), .ready_o(r16_o),
    .operation_i(op16), .status_i(st16), .operand1_i(a16), .operand2_i(b16),
    .valid_o(vo16), .ready_i(ri16), .result_o(res16), .status_o(so16));

  typedef struct {
    logic [4:0] op;
    logic [7:0] st;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] sto;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [7:0] st;
  } exp_t;

  vec_t tbl[15];
  exp_t sb_q[$];
  exp_t nxt_exp;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   acc, dlv, obs_ready, have_hold = 1'b0;
  logic [7:0] hold_res, hold_st;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Behavioural model: plain integer arithmetic on the flag rules
  function automatic void model(input int w, input logic [4:0] op, input logic [7:0] st,
                                input int a, input int b, output int res, output logic [7:0] so);
    int m, half, sa, sb, c, t, ts, bin, carry, d, da, db;
    bit nz;
    m    = 1 << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    c    = st[0] ? 1 : 0;
    so   = st;
    res  = a;
    nz   = 1'b1;
    bin  = -1;
    case (op)
      c_OP_ADD: begin
        t = a + b + c; res = t % m; so[0] = (t >= m);
        ts = sa + sb + c; so[6] = (ts < -half) || (ts >= half);
        bin = res;
        if (st[3]) begin
          res = 0; carry = c;
          for (int k = 0; k < w / 4; k++) begin
            da = (a >> (4 * k)) & 15; db = (b >> (4 * k)) & 15;
            d = da + db + carry;
            carry = (d > 9) ? 1 : 0;
            if (carry == 1) d -= 10;
            res += d << (4 * k);
          end
          so[0] = (carry == 1);
        end
      end
      c_OP_SUB: begin
        t = b - a - (1 - c); res = (t + m) % m; so[0] = (t >= 0);
        ts = sb - sa - (1 - c); so[6] = (ts < -half) || (ts >= half);
        bin = res;
        if (st[3]) begin
          res = 0; carry = c;
          for (int k = 0; k < w / 4; k++) begin
            da = (a >> (4 * k)) & 15; db = (b >> (4 * k)) & 15;
            d = db - da - (1 - carry);
            carry = (d >= 0) ? 1 : 0;
            if (d < 0) d += 10;
            res += d << (4 * k);
          end
          so[0] = (carry == 1);
        end
      end
      c_OP_CMP: begin t = b - a; res = (t + m) % m; so[0] = (b >= a); end
      c_OP_AND: res = a & b;
      c_OP_ORA: res = a | b;
      c_OP_XOR: res = a ^ b;
      c_OP_INC: res = (a + 1) % m;
      c_OP_DEC: res = (a - 1 + m) % m;
      c_OP_SHL: begin so[0] = (a >= half); res = (a * 2) % m; end
      c_OP_SHR: begin so[0] = (a % 2 == 1); res = a / 2; end
      c_OP_ROL: begin so[0] = (a >= half); res = (a * 2) % m + c; end
      c_OP_ROR: begin so[0] = (a % 2 == 1); res = a / 2 + c * half; end
      c_OP_ITO: res = a;
      c_OP_BRK: begin so[4] = 1'b1; so[2] = 1'b1; nz = 1'b0; end
      c_OP_ITF: begin so = 8'(a % 256); nz = 1'b0; end
      c_OP_CLC: begin so[0] = 1'b0; nz = 1'b0; end
      c_OP_SEC: begin so[0] = 1'b1; nz = 1'b0; end
      c_OP_CLD: begin so[3] = 1'b0; nz = 1'b0; end
      c_OP_SED: begin so[3] = 1'b1; nz = 1'b0; end
      c_OP_CLI: begin so[2] = 1'b0; nz = 1'b0; end
      c_OP_SEI: begin so[2] = 1'b1; nz = 1'b0; end
      c_OP_CLV: begin so[6] = 1'b0; nz = 1'b0; end
      default:  nz = 1'b0;
    endcase
    if (nz) begin
      if (bin < 0) bin = res;
      so[7] = (bin >= half);
      so[1] = (bin == 0);
    end
  endfunction

  // One clock cycle: sample at negedge, score transfers, then pass the edge
  task automatic step();
    @(negedge clk);
    dlv       = valid_o && ready_i;
    acc       = valid_i && ready_o;
    obs_ready = ready_o;
    if (have_hold && valid_o) begin
      check("hold_result", result_o, hold_res);
      check("hold_status", status_o, hold_st);
    end
    have_hold = valid_o && !ready_i;
    hold_res  = result_o;
    hold_st   = status_o;
    if (dlv) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_output result=%0h required no transfer", result_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", result_o, e.res);
        check("status", status_o, e.st);
      end
    end
    if (acc) sb_q.push_back(nxt_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input int idx);
    operation_i = tbl[idx].op; status_i = tbl[idx].st;
    operand1_i  = tbl[idx].a;  operand2_i = tbl[idx].b;
    nxt_exp.res = tbl[idx].res; nxt_exp.st = tbl[idx].sto;
  endtask

  task automatic run16(input string nm, input logic [4:0] op, input logic [7:0] st,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic [7:0] es);
    bit got;
    int lat;
    op16 = op; st16 = st; a16 = a; b16 = b; v16 = 1'b1; ri16 = 1'b1;
    @(negedge clk);
    check({nm, "_accept"}, r16_o, 1);
    @(posedge clk); #1;
    v16 = 1'b0; got = 1'b0; lat = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (vo16 && !got) begin
        got = 1'b1; lat = k;
        check({nm, "_result"}, res16, er);
        check({nm, "_status"}, so16, es);
      end
    end
    check({nm, "_delivered"}, got, 1);
    check({nm, "_latency"}, lat, 2);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] so;
    logic [3:0] h, l;

    tbl[0]  = '{c_OP_ADD, 8'h08, 8'h58, 8'h46, 8'h04, 8'hC9};
    tbl[1]  = '{c_OP_ADD, 8'h00, 8'h7F, 8'h01, 8'h80, 8'hC0};
    tbl[2]  = '{c_OP_SUB, 8'h01, 8'h20, 8'h10, 8'hF0, 8'h80};
    tbl[3]  = '{c_OP_CMP, 8'h00, 8'h33, 8'h33, 8'h00, 8'h03};
    tbl[4]  = '{c_OP_AND, 8'h81, 8'hF0, 8'h0F, 8'h00, 8'h03};
    tbl[5]  = '{c_OP_SHL, 8'h00, 8'h81, 8'h00, 8'h02, 8'h01};
    tbl[6]  = '{c_OP_ROR, 8'h01, 8'h02, 8'h00, 8'h81, 8'h80};
    tbl[7]  = '{c_OP_BRK, 8'h82, 8'h55, 8'h00, 8'h55, 8'h96};
    tbl[8]  = '{c_OP_ITF, 8'hFF, 8'h3C, 8'h00, 8'h3C, 8'h3C};
    tbl[9]  = '{c_OP_SEC, 8'h00, 8'h11, 8'h00, 8'h11, 8'h01};
    tbl[10] = '{c_OP_CLV, 8'hFF, 8'h22, 8'h00, 8'h22, 8'hBF};
    tbl[11] = '{c_OP_DEC, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h80};
    tbl[12] = '{5'd31,    8'hA5, 8'h42, 8'h99, 8'h42, 8'hA5};
    tbl[13] = '{c_OP_SUB, 8'h09, 8'h05, 8'h12, 8'h07, 8'h09};
    tbl[14] = '{c_OP_INC, 8'h41, 8'hFF, 8'h00, 8'h00, 8'h43};

    // Reset state
    #12;
    check("reset_valid_o", valid_o, 0);
    check("reset_result_o", result_o, 0);
    check("reset_status_o", status_o, 0);
    check("reset_ready_o", ready_o, 1);
    @(posedge clk); #2;
    rst_i = 1'b0;

    // Table vectors at full throughput; the first must be taken right away
    ready_i = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      load_vec(i);
      step();
      check("table_accept", acc, 1);
    end
    valid_i = 1'b0;
    repeat (4) step();
    check("table_drained", sb_q.size(), 0);

    // Latency: accept, one empty cycle, result on the second
    load_vec(0);
    valid_i = 1'b1;
    step();
    check("lat_accept", acc, 1);
    valid_i = 1'b0;
    step();
    check("lat_cycle1_no_output", dlv, 0);
    step();
    check("lat_cycle2_output", dlv, 1);

    // Backpressure: three ops with the sink stalled, then released
    ready_i = 1'b0;
    valid_i = 1'b1;
    load_vec(1); step(); check("bp_accept_a", acc, 1);
    load_vec(2); step(); check("bp_accept_b", acc, 1);
    load_vec(3); step(); check("bp_ready_o_low", obs_ready, 0);
    step();              check("bp_still_stalled", acc, 0);
    ready_i = 1'b1;
    step();              check("bp_accept_c", acc, 1); check("bp_out_a", dlv, 1);
    valid_i = 1'b0;
    step();              check("bp_out_b", dlv, 1);
    step();              check("bp_out_c", dlv, 1);
    step();              check("bp_idle", dlv, 0);

    // Reset with two ops in flight: discarded, outputs cleared at once
    ready_i = 1'b0;
    valid_i = 1'b1;
    load_vec(4); step();
    load_vec(5); step();
    valid_i = 1'b0;
    step();
    check("rst_inflight_valid", valid_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_async_valid_o", valid_o, 0);
    check("rst_async_result_o", result_o, 0);
    check("rst_async_status_o", status_o, 0);
    check("rst_async_ready_o", ready_o, 1);
    sb_q.delete();
    have_hold = 1'b0;
    @(posedge clk); #2;
    rst_i   = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_no_output", dlv, 0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      valid_i     = ($urandom_range(0, 3) != 0);
      ready_i     = ($urandom_range(0, 9) < 7);
      operation_i = 5'($urandom_range(0, 23));
      status_i    = 8'($urandom);
      if (status_i[3]) begin
        h = 4'($urandom_range(0, 9)); l = 4'($urandom_range(0, 9)); operand1_i = {h, l};
        h = 4'($urandom_range(0, 9)); l = 4'($urandom_range(0, 9)); operand2_i = {h, l};
      end else begin
        operand1_i = 8'($urandom);
        operand2_i = 8'($urandom);
      end
      model(8, operation_i, status_i, int'(operand1_i), int'(operand2_i), r, so);
      nxt_exp.res = r[7:0];
      nxt_exp.st  = so;
      step();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) step();
    check("random_drained", sb_q.size(), 0);

    // 16-bit build
    run16("w16_add_wrap", c_OP_ADD, 8'h00, 16'hFFFF, 16'h0001, 16'h0000, 8'h03);
    run16("w16_add_bcd",  c_OP_ADD, 8'h08, 16'h1999, 16'h0001, 16'h2000, 8'h08);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
